// File: rtl/seq_expect_pkg.sv
// seq_expect_pkg: shared FSM states and default sizes for the sequence checker
package seq_expect_pkg;
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    RUN        = 2'd2
  } state_e;
  localparam int DEF_NUM_STEPS = 4;
  localparam int DEF_SIG_W     = 3;
  localparam int DEF_TMO_W     = 16;
  localparam int CNT_W         = 16;
endpackage

// File: rtl/seq_expect_timer.sv
// seq_expect_timer: first-step wait timer; a zero limit never expires
module seq_expect_timer #(
  parameter int TMO_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [TMO_W-1:0] tmo_i,
  output logic             expired_o
);
  logic [TMO_W-1:0] cnt_q, cnt_d;
  assign cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  // expiry fires on the compare that would bring the count up to the limit
  assign expired_o = en_i && (tmo_i != '0) && (cnt_q + 1'b1 == tmo_i);
  // count waited cycles
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/seq_expect_checker.sv
// seq_expect_checker: checks that a masked signal sequence occurs on consecutive cycles
module seq_expect_checker
  import seq_expect_pkg::*;
#(
  parameter int NUM_STEPS = DEF_NUM_STEPS,
  parameter int SIG_W     = DEF_SIG_W,
  parameter int TMO_W     = DEF_TMO_W,
  localparam int IDX_W    = NUM_STEPS > 1 ? $clog2(NUM_STEPS) : 1,
  localparam int CFG_W    = NUM_STEPS * SIG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [SIG_W-1:0] sig,
  input  logic [CFG_W-1:0] step_mask,
  input  logic [CFG_W-1:0] step_val,
  input  logic [TMO_W-1:0] timeout,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic [IDX_W-1:0] fail_step,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);
  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, fstep_q, fstep_d;
  logic [CFG_W-1:0] mask_q, mask_d, val_q, val_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             pass_q, pass_d, fail_q, fail_d;
  logic [CNT_W-1:0] pcnt_q, fcnt_q;
  logic             hit, last, tclr, expired;
  logic [SIG_W-1:0] cur_mask, cur_val;
  assign cur_mask = mask_q[idx_q*SIG_W +: SIG_W];
  assign cur_val  = val_q[idx_q*SIG_W +: SIG_W];
  assign hit      = ((sig ^ cur_val) & cur_mask) == '0;
  assign last     = idx_q == IDX_W'(NUM_STEPS - 1);
  seq_expect_timer #(.TMO_W(TMO_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (tclr),
    .en_i     (state_q == WAIT_FIRST),
    .tmo_i    (tmo_q),
    .expired_o(expired)
  );
  // sequence FSM: arm, wait for step 0, then walk remaining steps one per cycle
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    fstep_d = fstep_q;
    mask_d  = mask_q;
    val_d   = val_q;
    tmo_d   = tmo_q;
    pass_d  = 1'b0;
    fail_d  = 1'b0;
    tclr    = 1'b0;
    case (state_q)
      IDLE: if (start && !abort) begin
        mask_d  = step_mask;
        val_d   = step_val;
        tmo_d   = timeout;
        idx_d   = '0;
        tclr    = 1'b1;
        state_d = WAIT_FIRST;
      end
      WAIT_FIRST:
        if (abort) state_d = IDLE;
        else if (hit) begin
          if (NUM_STEPS == 1) begin
            pass_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d   = IDX_W'(1);
            state_d = RUN;
          end
        end else if (expired) begin
          fail_d  = 1'b1;
          fstep_d = '0;
          state_d = IDLE;
        end
      RUN:
        if (abort) state_d = IDLE;
        else if (hit && last) begin
          pass_d  = 1'b1;
          state_d = IDLE;
        end else if (hit) idx_d = idx_q + 1'b1;
        else begin
          fail_d  = 1'b1;
          fstep_d = idx_q;
          state_d = IDLE;
        end
      default: state_d = IDLE;
    endcase
  end
  // state, latched configuration, result pulses and saturating counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      fstep_q <= '0;
      mask_q  <= '0;
      val_q   <= '0;
      tmo_q   <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      pcnt_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fstep_q <= fstep_d;
      mask_q  <= mask_d;
      val_q   <= val_d;
      tmo_q   <= tmo_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      if (pass_d && pcnt_q != '1) pcnt_q <= pcnt_q + 1'b1;
      if (fail_d && fcnt_q != '1) fcnt_q <= fcnt_q + 1'b1;
    end
  end
  assign busy      = state_q != IDLE;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign fail_step = fstep_q;
  assign pass_cnt  = pcnt_q;
  assign fail_cnt  = fcnt_q;
endmodule

// File: tb/tb_seq_expect_checker.sv
// tb_seq_expect_checker: directed scenarios plus randomized traces against a trace-level model
module tb_seq_expect_checker;
  localparam int N  = 4;
  localparam int SW = 3;
  localparam int TW = 16;
  localparam int MW = N * SW;
  localparam logic [MW-1:0] CFG_M = {3'b100, 3'b100, 3'b010, 3'b001};
  localparam logic [MW-1:0] CFG_V = {3'b000, 3'b100, 3'b010, 3'b001};
  logic          clk = 1'b0;
  logic          rst_n, start, abort;
  logic [SW-1:0] sig;
  logic [MW-1:0] step_mask, step_val;
  logic [TW-1:0] timeout;
  logic          busy, pass, fail;
  logic [1:0]    fail_step;
  logic [15:0]   pass_cnt, fail_cnt;
  int n_tests = 0;
  int n_fail  = 0;
  int exp_pc  = 0;
  int exp_fc  = 0;
  seq_expect_checker #(.NUM_STEPS(N), .SIG_W(SW), .TMO_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .sig(sig),
    .step_mask(step_mask), .step_val(step_val), .timeout(timeout),
    .busy(busy), .pass(pass), .fail(fail), .fail_step(fail_step),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic bit step_ok(input logic [MW-1:0] m, input logic [MW-1:0] v, input int i, input logic [SW-1:0] x);
    return ((x ^ v[i*SW +: SW]) & m[i*SW +: SW]) == '0;
  endfunction
  task automatic chk_cnts(input string nm);
    chk({nm, "_pass_cnt"}, pass_cnt, exp_pc);
    chk({nm, "_fail_cnt"}, fail_cnt, exp_fc);
  endtask
  task automatic run_seq(input string nm, input bit bad_b, input bit restart, input bit rst5);
    step_mask = CFG_M;
    step_val  = CFG_V;
    timeout   = 10;
    sig       = '0;
    start     = 1'b1;
    tick;
    start = 1'b0;
    chk({nm, "_busy_rise"}, busy, 1);
    for (int c = 1; c <= 6; c++) begin
      sig   = c == 3 ? 3'b001 : c == 4 ? (bad_b ? 3'b000 : 3'b010) : c == 5 ? 3'b100 : 3'b000;
      start = restart && c == 4;
      if (restart && c == 4) step_val = MW'($urandom);
      rst_n = !(rst5 && c == 5);
      tick;
      if (rst5 && c == 5) begin
        exp_pc = 0;
        exp_fc = 0;
        chk({nm, "_rst_busy"}, busy, 0);
        chk({nm, "_rst_pass"}, pass, 0);
        chk({nm, "_rst_fail"}, fail, 0);
        chk({nm, "_rst_fstep"}, fail_step, 0);
        chk_cnts({nm, "_rst"});
      end else begin
        chk({nm, "_pass"}, pass, !bad_b && !rst5 && c == 6);
        chk({nm, "_fail"}, fail, bad_b && c == 4);
        chk({nm, "_busy"}, busy, rst5 ? c < 5 : bad_b ? c < 4 : c < 6);
      end
    end
    rst_n = 1'b1;
    start = 1'b0;
    if (bad_b) begin
      exp_fc++;
      chk({nm, "_fstep"}, fail_step, 1);
    end else if (!rst5) exp_pc++;
    tick;
    chk({nm, "_idle_after"}, busy, 0);
    chk({nm, "_no_extra_pass"}, pass, 0);
    chk_cnts(nm);
  endtask
  task automatic rand_trial(input int k);
    logic [MW-1:0] m, v;
    logic [TW-1:0] to;
    logic [SW-1:0] s [1:48];
    logic [SW-1:0] km, kv;
    int  f, bs, first, d, a, e, fs;
    bit  bad, res, ab;
    m   = MW'($urandom);
    v   = MW'($urandom);
    to  = TW'($urandom_range(0, 8));
    f   = $urandom_range(1, 12);
    bad = $urandom_range(0, 2) == 0;
    bs  = $urandom_range(0, N - 1);
    for (int t = 1; t <= 48; t++) begin
      s[t] = SW'($urandom);
      if (t >= f && t - f < N) begin
        km   = m[(t-f)*SW +: SW];
        kv   = v[(t-f)*SW +: SW];
        s[t] = (s[t] & ~km) | (kv & km);
        if (bad && t - f == bs) s[t] = s[t] ^ km;
      end
    end
    first = 0;
    d     = 0;
    res   = 1'b0;
    fs    = 0;
    for (int t = 1; t <= 41; t++) begin
      if (step_ok(m, v, 0, s[t])) begin
        first = t;
        break;
      end
      if (to != 0 && t == int'(to)) begin
        d = t;
        break;
      end
    end
    if (first > 0) begin
      d   = first + N - 1;
      res = 1'b1;
      for (int i = 1; i < N; i++)
        if (!step_ok(m, v, i, s[first+i])) begin
          d   = first + i;
          res = 1'b0;
          fs  = i;
          break;
        end
    end
    a  = $urandom_range(0, 3) == 0 ? $urandom_range(1, 40) : 41;
    ab = !(d != 0 && d < a);
    e  = ab ? a : d;
    step_mask = m;
    step_val  = v;
    timeout   = to;
    abort     = 1'b0;
    sig       = SW'($urandom);
    start     = 1'b1;
    tick;
    chk($sformatf("r%0d_busy_rise", k), busy, 1);
    for (int t = 1; t <= e; t++) begin
      sig       = s[t];
      abort     = t == a;
      start     = $urandom_range(0, 3) == 0;
      step_mask = MW'($urandom);
      step_val  = MW'($urandom);
      timeout   = TW'($urandom);
      tick;
      chk($sformatf("r%0d_t%0d_pass", k, t), pass, !ab && t == e && res);
      chk($sformatf("r%0d_t%0d_fail", k, t), fail, !ab && t == e && !res);
      chk($sformatf("r%0d_t%0d_busy", k, t), busy, t < e);
    end
    start = 1'b0;
    abort = 1'b0;
    if (!ab && res) exp_pc++;
    if (!ab && !res) begin
      exp_fc++;
      chk($sformatf("r%0d_fstep", k), fail_step, fs);
    end
    chk_cnts($sformatf("r%0d", k));
  endtask
  initial begin
    int bad_cnt;
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    sig       = '0;
    step_mask = '0;
    step_val  = '0;
    timeout   = '0;
    tick;
    tick;
    rst_n = 1'b1;
    chk("reset_busy", busy, 0);
    chk("reset_pass", pass, 0);
    chk("reset_fail", fail, 0);
    chk("reset_fstep", fail_step, 0);
    chk_cnts("reset");
    run_seq("seq_pass", 1'b0, 1'b0, 1'b0);
    run_seq("seq_fail_b", 1'b1, 1'b0, 1'b0);
    step_mask = CFG_M;
    step_val  = CFG_V;
    timeout   = 10;
    sig       = '0;
    start     = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      tick;
      chk($sformatf("tmo_c%0d_fail", c), fail, c == 10);
      chk($sformatf("tmo_c%0d_busy", c), busy, c < 10);
    end
    exp_fc++;
    chk("tmo_fstep", fail_step, 0);
    chk_cnts("tmo");
    timeout = 0;
    start   = 1'b1;
    tick;
    start   = 1'b0;
    bad_cnt = 0;
    for (int c = 1; c <= 1000; c++) begin
      tick;
      if (busy !== 1'b1 || pass !== 1'b0 || fail !== 1'b0) bad_cnt++;
    end
    chk("inf_wait_held", bad_cnt, 0);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_pass", pass, 0);
    chk("abort_fail", fail, 0);
    chk_cnts("abort");
    start = 1'b1;
    abort = 1'b1;
    tick;
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle", busy, 0);
    tick;
    chk("start_abort_still_idle", busy, 0);
    run_seq("seq_restart", 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 80; k++) rand_trial(k);
    run_seq("seq_reset", 1'b0, 1'b0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
